// File: rtl/link_udc_collect.sv
// DC-link voltage collector: per-link report store with timeout
// liveness, serial scan into three phase buses, periodic snapshot.
module link_udc_collect #(
  parameter int PRESCALE      = 20,
  parameter int TIMEOUT_TICKS = 100
) (
  input  logic         i_clk_20M,
  input  logic         i_reset_n,
  input  logic         i_rx_valid,
  input  logic [1:0]   i_rx_phase,
  input  logic [4:0]   i_rx_link,
  input  logic [15:0]  i_rx_udc,
  input  logic         i_rx_fault,
  input  logic [71:0]  i_link_enable,
  output logic [383:0] o_LinkUdcA_BUS,
  output logic [383:0] o_LinkUdcB_BUS,
  output logic [383:0] o_LinkUdcC_BUS,
  output logic [15:0]  o_LinkNumA_Work,
  output logic [15:0]  o_LinkNumB_Work,
  output logic [15:0]  o_LinkNumC_Work,
  output logic [71:0]  o_link_alive,
  output logic         o_update
);
  localparam int NLINK = 24;
  localparam int NENT  = 72;
  localparam logic [4:0]  SCAN_LAST = 5'd24;
  localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
  localparam logic [7:0]  AGE_LIMIT = 8'(TIMEOUT_TICKS);
  localparam logic [7:0]  AGE_MAX   = 8'hFF;

  logic [NENT-1:0][15:0] udc;
  logic [NENT-1:0][7:0]  age;
  logic [NENT-1:0]       flt;
  logic [NENT-1:0]       working;
  logic [15:0]           preCnt;
  logic                  tick;
  logic                  wrHit;
  logic [6:0]            wrIdx;
  logic [4:0]            scanIdx;
  logic                  scanLast;
  logic [2:0][6:0]       rdIdx;
  logic [2:0][15:0]      scanVal;
  logic [2:0]            scanWork;
  logic [2:0][383:0]     stage;
  logic [2:0][383:0]     bus;
  logic [2:0][4:0]       acc;
  logic [2:0][4:0]       num;
  logic                  snapDone;

  assign tick     = (preCnt == PRE_LAST);
  assign scanLast = (scanIdx == SCAN_LAST);
  assign wrHit    = i_rx_valid && (i_rx_phase != 2'd3)
                 && (i_rx_link < 5'd24);
  assign wrIdx    = 7'(i_rx_phase) * 7'd24 + 7'(i_rx_link);

  always_ff @(posedge i_clk_20M or negedge i_reset_n) begin
    if (!i_reset_n) begin
      preCnt <= '0;
    end else begin
      preCnt <= tick ? '0 : preCnt + 16'd1;
    end
  end

  // A report landing on a tick edge wins: age restarts at 0.
  always_ff @(posedge i_clk_20M or negedge i_reset_n) begin
    if (!i_reset_n) begin
      udc <= '0;
      flt <= '0;
      age <= '1;
    end else begin
      for (int i = 0; i < NENT; i++) begin
        if (wrHit && (wrIdx == 7'(i))) begin
          udc[i] <= i_rx_udc;
          flt[i] <= i_rx_fault;
          age[i] <= '0;
        end else if (tick && (age[i] != AGE_MAX)) begin
          age[i] <= age[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NENT; i++) begin
      o_link_alive[i] = (age[i] < AGE_LIMIT);
      working[i] = i_link_enable[i] & o_link_alive[i] & ~flt[i];
    end
  end

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdIdx[p]    = 7'(p * NLINK) + {2'b00, scanIdx};
      scanWork[p] = 1'b0;
      scanVal[p]  = '0;
      if (!scanLast) begin
        scanWork[p] = working[rdIdx[p]];
        scanVal[p]  = scanWork[p] ? udc[rdIdx[p]] : 16'd0;
      end
    end
  end

  // Bus and count publish on the same edge so they always agree.
  always_ff @(posedge i_clk_20M or negedge i_reset_n) begin
    if (!i_reset_n) begin
      scanIdx  <= '0;
      stage    <= '0;
      acc      <= '0;
      bus      <= '0;
      num      <= '0;
      snapDone <= 1'b0;
      o_update <= 1'b0;
    end else begin
      snapDone <= scanLast;
      o_update <= snapDone;
      if (scanLast) begin
        scanIdx <= '0;
        bus     <= stage;
        num     <= acc;
        acc     <= '0;
      end else begin
        scanIdx <= scanIdx + 5'd1;
        for (int p = 0; p < 3; p++) begin
          stage[p] <= {scanVal[p], stage[p][383:16]};
          acc[p]   <= acc[p] + 5'(scanWork[p]);
        end
      end
    end
  end

  assign o_LinkUdcA_BUS  = bus[0];
  assign o_LinkUdcB_BUS  = bus[1];
  assign o_LinkUdcC_BUS  = bus[2];
  assign o_LinkNumA_Work = {11'd0, num[0]};
  assign o_LinkNumB_Work = {11'd0, num[1]};
  assign o_LinkNumC_Work = {11'd0, num[2]};

endmodule

// File: doc/link_udc_collect.md
# link_udc_collect

Collects per-submodule DC-link voltage reports from the link receivers into three 24-slot phase buses (A/B/C, 16 bits per slot). Also tracks per-link liveness by timeout and counts the working links per phase. Publishes a consistent snapshot of buses and counts every 25 clocks. It sits directly upstream of the phase-average Udc calculator and drives its `i_LinkUdc{A,B,C}_BUS` and `i_LinkNum{A,B,C}_Work` inputs.

## Interface
- `PRESCALE`, 20: clocks per age tick (1 us at 20 MHz); legal range 1..65535.
- `TIMEOUT_TICKS`, 100: a link is alive while its age is below this value; legal range 1..255.
- `i_clk_20M` in 1: single clock, 20 MHz.
- `i_reset_n` in 1: reset, asynchronous and active-low.
- `i_rx_valid` in 1: one-cycle report strobe.
- `i_rx_phase` in 2: 0=A, 1=B, 2=C; 3 means the report is ignored.
- `i_rx_link` in 5: link index 0..23; values 24..31 mean the report is ignored.
- `i_rx_udc` in 16: reported link voltage, unsigned.
- `i_rx_fault` in 1: submodule fault flag carried with the report.
- `i_link_enable` in 72: configured-link mask; bit p*24+l is phase p, link l.
- `o_LinkUdcA_BUS`, `o_LinkUdcB_BUS`, `o_LinkUdcC_BUS` out 384 each: slot l is bits [16l+15:16l]; a non-working link's slot reads 0.
- `o_LinkNumA_Work`, `o_LinkNumB_Work`, `o_LinkNumC_Work` out 16 each: working-link count per phase, 0..24.
- `o_link_alive` out 72: live alive flags, same bit map as `i_link_enable`.
- `o_update` out 1: one-cycle pulse on the cycle after a new snapshot is presented.

## Operation
- **Per-link state (72 entries):** `udc[15:0]`, `flt`, `age[7:0]`.
- **Report write:** when `i_rx_valid`=1, `i_rx_phase`<3 and `i_rx_link`<24, the addressed entry loads `udc<=i_rx_udc`, `flt<=i_rx_fault` and `age<=0` on that edge. Any other report is dropped silently.
- **Age tick:**
  - A prescaler counts 0..PRESCALE-1 and asserts the tick at PRESCALE-1.
  - On a tick, every entry's age increments and saturates at 255.
  - If a report write and a tick hit the same entry on the same edge, the write wins and age becomes 0.
- **Link status:**
  - alive = (age < TIMEOUT_TICKS).
  - working = enable & alive & !flt.
- **Scan counter `scan_idx` (0..24):**
  - idx 0..23:
    - For all three phases in parallel, shift the value (working ? udc : 0) into a staging bus from the top: `stage <= {val, stage[383:16]}`. After 24 shifts, link 0 sits in bits [15:0].
    - Add working to a per-phase 5-bit accumulator.
    - Entry state is sampled as registered before that cycle's edge, so a write on the same cycle is not seen until the next scan.
  - idx 24:
    - Copy the staging buses to the `o_LinkUdc*_BUS` outputs and the accumulators to the `o_LinkNum*_Work` outputs (zero-extended).
    - Assert `o_update` on the following cycle.
    - Clear the accumulators and wrap `scan_idx` to 0.
- **Snapshot consistency:** the bus outputs and count outputs always change on the same edge, so the average stage never sees a bus that does not match its divisor.
- **No working links:** a phase with zero working links outputs an all-zero bus and a count of 0. Guarding the divide-by-zero is the consumer's job.

## Timing
- **Reset (asynchronous):**
  - All udc and flt cleared; all age set to 255, so every link is dead.
  - Prescaler and `scan_idx` set to 0; accumulators and staging cleared.
  - All buses 0, all counts 0, `o_link_alive`=0, `o_update`=0.
- **Snapshot rate:** one snapshot every 25 clocks. The first `o_update` pulse comes 26 clocks after reset release.
- **`o_link_alive`:** combinational from registered age, so it changes 1 clock after a report edge or a tick edge.
- **Report-to-output latency:**
  - Minimum 2 clocks, when the report lands just before its index is scanned.
  - Maximum 25+25 clocks: a report written on the edge of idx l's own scan cycle is not sampled until the next scan, so it is published about 2 snapshots later.
- **Timeout:** a link reported with age 0 goes dead after TIMEOUT_TICKS ticks, i.e. TIMEOUT_TICKS×PRESCALE clocks ±PRESCALE (default 2000 ±20 clocks, about 100 us).
- **Reset mid-scan:** the partial scan is discarded and outputs return to 0 immediately. No `o_update` is emitted until a full 25-clock scan has completed after release.

## Test plan
- **Single report:** reset release, all enables=1; write phase 0, link 5, udc=0x0320, fault=0.
  - Next `o_update` snapshot: `o_LinkUdcA_BUS[95:80]`=0x0320, `o_LinkNumA_Work`=1, all other slots and counts 0.
- **Full load:** write all 72 links with udc=1000+l and fault=0, then wait two snapshots.
  - Each `o_LinkNum*_Work`=24.
  - Slot 23 of bus B equals 1023.
- **Masking:** after the full load, clear enable bit 30 (B link 6), then write fault=1 to C link 0.
  - Next snapshot: count B=23 and slot B6=0; count C=23 and slot C0=0.
  - `o_link_alive[30]` stays 1.
- **Timeout:** use PRESCALE=4, TIMEOUT_TICKS=3, report A link 2 once, and stop.
  - `o_link_alive[2]` falls 12±4 clocks later.
  - The following snapshot shows slot A2=0 and count A=0.
  - Re-report A link 2 and the link is restored on the next snapshot.
- **Illegal and simultaneous events:**
  - Reports with phase=3 or link=27 change nothing.
  - A report coinciding with a tick leaves age=0.
- **Mid-scan reset:** assert `i_reset_n`=0 at scan_idx=10.
  - All outputs go to 0 asynchronously.
  - After release, the first `o_update` comes exactly 26 clocks later with counts 0.
